// File: rtl/mimo_zf_ctrl_pkg.sv
// Shared constants and types for the 2x2 MIMO zero-forcing controller.
package mimo_pkg;
  localparam int DATA_W = 16;
  localparam int NFFT   = 64;
  localparam int CNT_W  = $clog2(NFFT);

  typedef enum logic [1:0] {
    NOCOEF = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } zf_state_e;

  // H_inv element addresses; also the bank slot order, H00 in the MSBs of zf_h.
  localparam logic [1:0] H00 = 2'd0;
  localparam logic [1:0] H01 = 2'd1;
  localparam logic [1:0] H10 = 2'd2;
  localparam logic [1:0] H11 = 2'd3;
endpackage

// File: rtl/mimo_zf_ctrl_coef_bank.sv
// Double-buffered H_inv store: shadow bank takes writes, active bank feeds the datapath.
module zf_coef_bank
  import mimo_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_addr_i,
  input  logic [2*DATA_W-1:0]     wr_data_i,
  input  logic                    commit_i,
  input  logic                    can_swap_i,
  output logic [0:3][2*DATA_W-1:0] active_o,
  output logic                    wr_err_o
);
  logic [0:3][2*DATA_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                     pend_q, pend_d, err_q;
  logic                     wr_ok, commit_ok;

  // While a commit is pending the shadow is frozen, so writes and commits are refused.
  assign wr_ok     = wr_en_i & ~pend_q;
  assign commit_ok = commit_i & ~pend_q;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (wr_ok) shadow_d[wr_addr_i] = wr_data_i;
    // shadow_d already holds a same-cycle write, so a commit includes it.
    if (can_swap_i && (commit_ok || pend_q)) begin
      active_d = shadow_d;
      pend_d   = 1'b0;
    end else if (commit_ok) begin
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      err_q    <= (wr_en_i | commit_i) & pend_q;
    end
  end

  assign active_o = active_q;
  assign wr_err_o = err_q;
endmodule

// File: rtl/mimo_zf_ctrl.sv
// Frame sequencer for mimo_zf_2x2: beat forwarding, subcarrier indexing and bank swap timing.
module mimo_zf_ctrl
  import mimo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_wr_en,
  input  logic [1:0]            h_wr_addr,
  input  logic [2*DATA_W-1:0]   h_wr_data,
  input  logic                  h_commit,
  output logic                  h_wr_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [4*DATA_W-1:0]   s_data,
  output logic                  zf_in_valid,
  output logic [4*DATA_W-1:0]   zf_y,
  output logic [8*DATA_W-1:0]   zf_h,
  input  logic                  zf_out_valid,
  output logic [CNT_W-1:0]      sc_idx,
  output logic                  frame_done,
  output logic                  busy
);
  zf_state_e               state_q, state_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_W:0]          out_cnt_q, out_cnt_d;
  logic                    vld_q;
  logic [4*DATA_W-1:0]     y_q;
  logic [CNT_W-1:0]        idx_q;
  logic                    accept, can_swap;
  logic [0:3][2*DATA_W-1:0] h_act;

  assign s_ready    = (state_q == READY) || (state_q == STREAM);
  assign busy       = (state_q == STREAM) || (state_q == DRAIN);
  assign accept     = s_valid && s_ready;
  assign frame_done = (state_q == DRAIN) && (out_cnt_q == (CNT_W+1)'(NFFT));
  // The frame_done cycle is the boundary: swapping there lands before the next beat.
  assign can_swap   = ~busy | frame_done;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (busy && zf_out_valid) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      NOCOEF: if (h_commit) state_d = READY;
      READY: begin
        if (accept) begin
          state_d  = STREAM;
          in_cnt_d = CNT_W'(1);
        end
      end
      STREAM: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == CNT_W'(NFFT-1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done) begin
          state_d   = READY;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      default: state_d = NOCOEF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NOCOEF;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      vld_q     <= 1'b0;
      y_q       <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= accept;
      if (accept) begin
        y_q   <= s_data;
        idx_q <= in_cnt_q;
      end
    end
  end

  zf_coef_bank u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (h_wr_en),
    .wr_addr_i  (h_wr_addr),
    .wr_data_i  (h_wr_data),
    .commit_i   (h_commit),
    .can_swap_i (can_swap),
    .active_o   (h_act),
    .wr_err_o   (h_wr_err)
  );

  assign zf_in_valid = vld_q;
  assign zf_y        = y_q;
  assign sc_idx      = idx_q;
  assign zf_h        = h_act;
endmodule

// File: tb/tb_mimo_zf_ctrl.sv
// Directed bench for mimo_zf_ctrl; the ZF datapath is stood in for by a fixed-latency valid delay.
module tb_mimo_zf_ctrl;
  import mimo_pkg::*;
  localparam int LAT = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                h_wr_en = 1'b0;
  logic [1:0]          h_wr_addr = '0;
  logic [2*DATA_W-1:0] h_wr_data = '0;
  logic                h_commit = 1'b0;
  logic                h_wr_err;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [4*DATA_W-1:0] s_data = '0;
  logic                zf_in_valid;
  logic [4*DATA_W-1:0] zf_y;
  logic [8*DATA_W-1:0] zf_h;
  logic                zf_out_valid;
  logic [CNT_W-1:0]    sc_idx;
  logic                frame_done;
  logic                busy;
  logic [LAT-1:0]      ov_pipe;

  int checks = 0;
  int failures = 0;

  logic [127:0] G, G1, G2;

  mimo_zf_ctrl dut (
    .clk(clk), .rst_n(rst_n), .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .h_commit(h_commit), .h_wr_err(h_wr_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .zf_in_valid(zf_in_valid), .zf_y(zf_y), .zf_h(zf_h), .zf_out_valid(zf_out_valid),
    .sc_idx(sc_idx), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ov_pipe <= '0;
    else        ov_pipe <= {ov_pipe[LAT-2:0], zf_in_valid};
  assign zf_out_valid = ov_pipe[LAT-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int f, input int i);
    return {16'(f*256 + i), ~16'(i), 16'(i*3), 16'h8000 | 16'(i)};
  endfunction

  function automatic logic [127:0] hcat(input logic [31:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  128'(s_ready), 128'(0));
    chk({tag, "_vld"},  128'(zf_in_valid), 128'(0));
    chk({tag, "_y"},    128'(zf_y), 128'(0));
    chk({tag, "_h"},    zf_h, 128'(0));
    chk({tag, "_idx"},  128'(sc_idx), 128'(0));
    chk({tag, "_fd"},   128'(frame_done), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_err"},  128'(h_wr_err), 128'(0));
  endtask

  // Called at #1 after a rising edge; last write shares its cycle with the commit.
  task automatic load_commit(input logic [31:0] h0, h1, h2, h3);
    logic [31:0] hv [4];
    hv = '{h0, h1, h2, h3};
    s_valid = 1'b0;
    for (int a = 0; a < 4; a++) begin
      h_wr_en = 1'b1; h_wr_addr = 2'(a); h_wr_data = hv[a]; h_commit = (a == 3);
      @(posedge clk); #1;
    end
    h_wr_en = 1'b0; h_commit = 1'b0;
  endtask

  // mode 1: write H00 at beat 20, commit next cycle. mode 2: write H01+commit at beat 10,
  // dropped H10 write at beat 30. abort_at >= 0 stops driving at that beat.
  task automatic run_frame(input int f, input bit gate, input int mode, input int abort_at,
                           input logic [127:0] hx, input logic [127:0] hnext);
    int sent, got, outs, cyc, b;
    bit fd_exp, err_exp, inj, inj2, done;
    sent = 0; got = 0; outs = 0; cyc = 0;
    fd_exp = 0; err_exp = 0; inj = 0; inj2 = 0; done = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (zf_in_valid) begin
        chk("sc_idx", 128'(sc_idx), 128'(got));
        chk("zf_y", 128'(zf_y), 128'(pat(f, got)));
        got++;
      end
      chk("zf_h_frame", zf_h, hx);
      chk("frame_done", 128'(frame_done), 128'(fd_exp));
      chk("h_wr_err", 128'(h_wr_err), 128'(err_exp));
      if (sent == NFFT) chk("s_ready_drain", 128'(s_ready), 128'(0));
      else              chk("s_ready_strm", 128'(s_ready), 128'(1));
      fd_exp = 0; err_exp = 0;
      if (zf_out_valid) begin
        outs++;
        if (outs == NFFT) fd_exp = 1;
      end
      if (frame_done) done = 1;
      h_wr_en = 1'b0; h_commit = 1'b0;
      b = sent;
      if (abort_at >= 0 && b == abort_at) begin
        s_valid = 1'b0;
        done = 1;
      end else if (b < NFFT) begin
        s_valid = gate ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data  = pat(f, b);
        if (s_valid && s_ready) sent++;
      end else begin
        s_valid = 1'b0;
      end
      if (mode == 1) begin
        if (inj && !inj2) begin h_commit = 1'b1; inj2 = 1; end
        if (!inj && b == 20) begin
          h_wr_en = 1'b1; h_wr_addr = H00; h_wr_data = 32'h1234_0567; inj = 1;
        end
      end else if (mode == 2) begin
        if (!inj && b == 10) begin
          h_wr_en = 1'b1; h_wr_addr = H01; h_wr_data = 32'hABCD_1111; h_commit = 1'b1; inj = 1;
        end else if (!inj2 && b == 30) begin
          h_wr_en = 1'b1; h_wr_addr = H10; h_wr_data = 32'hDEAD_BEEF; inj2 = 1; err_exp = 1;
        end
      end
    end
    h_wr_en = 1'b0; h_commit = 1'b0;
    if (abort_at < 0) begin
      chk("frame_timeout", 128'(done), 128'(1));
      chk("beats", 128'(got), 128'(NFFT));
      @(posedge clk); #1;
      chk("fd_single", 128'(frame_done), 128'(0));
      chk("zf_h_next", zf_h, hnext);
      chk("post_busy", 128'(busy), 128'(0));
      chk("post_ready", 128'(s_ready), 128'(1));
    end
  endtask

  initial begin
    G  = hcat(32'h4000_0000, 32'hF000_0100, 32'h0200_FE00, 32'h3C00_0040);
    G1 = hcat(32'h1234_0567, 32'hF000_0100, 32'h0200_FE00, 32'h3C00_0040);
    G2 = hcat(32'h1234_0567, 32'hABCD_1111, 32'h0200_FE00, 32'h3C00_0040);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = pat(9, 0);
    repeat (100) begin
      @(posedge clk); #1;
      chk("nocoef_rdy", 128'(s_ready), 128'(0));
      chk("nocoef_vld", 128'(zf_in_valid), 128'(0));
      chk("nocoef_h", zf_h, 128'(0));
    end

    load_commit(G[127:96], G[95:64], G[63:32], G[31:0]);
    chk("load_h", zf_h, G);
    chk("load_rdy", 128'(s_ready), 128'(1));
    chk("load_busy", 128'(busy), 128'(0));

    run_frame(0, 1'b0, 0, -1, G, G);
    run_frame(1, 1'b0, 1, -1, G, G1);
    run_frame(2, 1'b1, 2, -1, G1, G2);
    run_frame(3, 1'b1, 0, -1, G2, G2);

    run_frame(4, 1'b0, 0, 30, G2, G2);
    chk("abort_busy", 128'(busy), 128'(1));
    s_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("rst_rdy", 128'(s_ready), 128'(0));
      chk("rst_vld", 128'(zf_in_valid), 128'(0));
      chk("rst_h", zf_h, 128'(0));
    end
    load_commit(G[127:96], G[95:64], G[63:32], G[31:0]);
    chk("reload_h", zf_h, G);
    run_frame(5, 1'b1, 0, -1, G, G);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
